// File: rtl/alu_resp_checker_if.sv
// alu_resp_checker_if: valid/ready sample bus carrying {A, B, op, Result, Zero} from the ALU side to the checker
interface alu_resp_checker_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic [31:0] in_result;
  logic        in_zero;
  modport master (output in_valid, in_a, in_b, in_op, in_result, in_zero, input in_ready);
  modport slave  (input in_valid, in_a, in_b, in_op, in_result, in_zero, output in_ready);
endinterface

// File: rtl/alu_resp_checker.sv
// alu_resp_checker: recomputes ALU results, counts pass/fail, latches first failure (ports: clk, rst, start, stop, bus, stats, ff_*, busy/done/all_pass)
module alu_resp_checker #(
  parameter int CNT_W      = 16,
  parameter bit CHECK_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  alu_resp_checker_if.slave bus,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_valid,
  output logic [2:0]       ff_op,
  output logic [31:0]      ff_a,
  output logic [31:0]      ff_b,
  output logic [31:0]      ff_exp,
  output logic [31:0]      ff_got,
  output logic             busy,
  output logic             done,
  output logic             all_pass
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t      state, state_n;
  logic        rdy, accept;
  logic [31:0] exp_in;
  logic        s1_v, s1_zero, s1_fail;
  logic [2:0]  s1_op;
  logic [31:0] s1_a, s1_b, s1_exp, s1_got;
  logic        s2_v, s2_fail;
  logic [2:0]  s2_op;
  logic [31:0] s2_a, s2_b, s2_exp, s2_got;
  assign bus.in_ready = rdy;
  assign accept       = bus.in_valid & rdy;
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = state == DONE;
  assign all_pass     = done && (fail_cnt == '0) && (pass_cnt != '0);
  always_comb begin
    state_n = start                                   ? RUN   :
              (state == RUN && stop)                  ? DRAIN :
              (state == DRAIN && !s1_v && !s2_v)      ? DONE  : state;
  end
  always_comb begin
    exp_in = bus.in_op == 3'd0 ? bus.in_a + bus.in_b :
             bus.in_op == 3'd1 ? bus.in_a - bus.in_b :
             bus.in_op == 3'd2 ? bus.in_a & bus.in_b :
             bus.in_op == 3'd3 ? bus.in_a | bus.in_b :
             bus.in_op == 3'd4 ? bus.in_a ^ bus.in_b :
             bus.in_op == 3'd5 ? ~(bus.in_a | bus.in_b) :
             bus.in_op == 3'd6 ? {31'd0, $signed(bus.in_a) < $signed(bus.in_b)} :
                                 bus.in_a << bus.in_b[4:0];
  end
  assign s1_fail = (s1_exp != s1_got) || (CHECK_ZERO && ((s1_exp == 32'd0) != s1_zero));
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    rdy   <= !rst && (state_n == RUN);
  end
  always_ff @(posedge clk) begin
    if (rst || start) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
    end
    if (accept) begin
      s1_a    <= bus.in_a;
      s1_b    <= bus.in_b;
      s1_op   <= bus.in_op;
      s1_got  <= bus.in_result;
      s1_zero <= bus.in_zero;
      s1_exp  <= exp_in;
    end
    if (s1_v) begin
      s2_fail <= s1_fail;
      s2_op   <= s1_op;
      s2_a    <= s1_a;
      s2_b    <= s1_b;
      s2_exp  <= s1_exp;
      s2_got  <= s1_got;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || start) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_op    <= '0;
      ff_a     <= '0;
      ff_b     <= '0;
      ff_exp   <= '0;
      ff_got   <= '0;
    end else if (s2_v) begin
      if (!s2_fail && !(&pass_cnt)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (s2_fail && !(&fail_cnt)) fail_cnt <= fail_cnt + CNT_W'(1);
      if (s2_fail && !ff_valid) begin
        ff_valid <= 1'b1;
        ff_op    <= s2_op;
        ff_a     <= s2_a;
        ff_b     <= s2_b;
        ff_exp   <= s2_exp;
        ff_got   <= s2_got;
      end
    end
  end
endmodule
